// File: rtl/trapezoid_raster_pkg.sv
// -----------------------------------------------------------------------------
// trapezoid_pkg
// Shared definitions for the trapezoid rasteriser: the control FSM state
// encoding and the two rendering mode values sampled alongside `nt`.
// No ports; imported by the top module.
// -----------------------------------------------------------------------------
package trapezoid_pkg;

  // Control FSM states of the top-level sequencer.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    ROW  = 3'd3,
    EMIT = 3'd4
  } state_e;

  // Rendering mode, sampled with the first point.
  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/trapezoid_raster_if.sv
// -----------------------------------------------------------------------------
// trapezoid_raster_if
// Bundles the point-command input and the pixel output handshake of the
// rasteriser.
//   nt, mode, xi, yi : point command (new trapezoid flag, mode, coordinates)
//   busy             : engine is loading or rendering
//   po, pr, xo, yo   : pixel valid / sink ready / pixel coordinates
// Modports:
//   master : the side that issues points and sinks pixels
//   slave  : the rasteriser itself
// -----------------------------------------------------------------------------
interface trapezoid_raster_if #(
  parameter int CW = 8
) ();

  logic          nt;
  logic          mode;
  logic [CW-1:0] xi;
  logic [CW-1:0] yi;
  logic          busy;
  logic          po;
  logic          pr;
  logic [CW-1:0] xo;
  logic [CW-1:0] yo;

  modport master (
    output nt, mode, xi, yi, pr,
    input  busy, po, xo, yo
  );

  modport slave (
    input  nt, mode, xi, yi, pr,
    output busy, po, xo, yo
  );

endinterface

// File: rtl/trapezoid_raster_edge_walker.sv
// -----------------------------------------------------------------------------
// trap_edge_walker
// One trapezoid edge: a restoring divider that turns the edge slope dx/dy into
// a floor quotient q and remainder r in [0, dy), followed by an incremental
// walker that tracks the exact edge position as integer x plus remainder.
//   clk, reset : clock, synchronous active-high reset
//   start      : load x0/dx/dy and begin the CW+1 cycle divide
//   step       : advance the edge by one row
//   x0         : edge x at the bottom row
//   dx         : signed top-minus-bottom x delta
//   dy         : row count minus one (yu - yd)
//   x          : current integer part of the edge position (signed)
//   rem_nz     : current fractional part is non-zero
//   done       : the divide completes on the coming clock edge
// -----------------------------------------------------------------------------
module trap_edge_walker #(
  parameter int CW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic [CW-1:0]      x0,
  input  logic signed [CW:0] dx,
  input  logic [CW-1:0]      dy,
  output logic signed [CW:0] x,
  output logic               rem_nz,
  output logic               done
);

  localparam int               CNT_W      = $clog2(CW + 2);
  localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(CW + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW:0]        acc_q, acc_d;   // partial remainder of the divide
  logic [CW:0]        nq_q, nq_d;     // dividend bits shift out, quotient bits shift in
  logic               neg_q, neg_d;
  logic [CW-1:0]      dy_q, dy_d;
  logic signed [CW:0] x_q, x_d;
  logic [CW:0]        rem_q, rem_d;

  logic [CW:0]        dx_mag_s;
  logic [CW+1:0]      trial_s;
  logic signed [CW:0] q_s;
  logic [CW:0]        r_s;
  logic [CW+1:0]      rem_sum_s;

  // Divider operand prep and conversion of the magnitude result to floor form.
  always_comb begin
    dx_mag_s = dx[CW] ? (-dx) : dx;
    trial_s  = {acc_q, nq_q[CW]};
    if (dy_q == {CW{1'b0}}) begin
      q_s = {(CW+1){1'b0}};
      r_s = {(CW+1){1'b0}};
    end else if (!neg_q) begin
      q_s = $signed(nq_q);
      r_s = acc_q;
    end else if (acc_q == {(CW+1){1'b0}}) begin
      // exact negative division: q = -|q|
      q_s = $signed(~nq_q + {{CW{1'b0}}, 1'b1});
      r_s = {(CW+1){1'b0}};
    end else begin
      // inexact negative division rounds toward -inf: q = -|q| - 1 = ~|q|
      q_s = $signed(~nq_q);
      r_s = {1'b0, dy_q} - acc_q;
    end
    rem_sum_s = {1'b0, rem_q} + {1'b0, r_s};
  end

  // Next-state for divider iteration and per-row edge advance.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    nq_d  = nq_q;
    neg_d = neg_q;
    dy_d  = dy_q;
    x_d   = x_q;
    rem_d = rem_q;
    if (start) begin
      cnt_d = DIV_CYCLES;
      acc_d = {(CW+1){1'b0}};
      nq_d  = dx_mag_s;
      neg_d = dx[CW];
      dy_d  = dy;
      x_d   = $signed({1'b0, x0});
      rem_d = {(CW+1){1'b0}};
    end else begin
      if (cnt_q != {CNT_W{1'b0}}) begin
        cnt_d = cnt_q - CNT_ONE;
        if (trial_s >= {2'b00, dy_q}) begin
          acc_d = trial_s[CW:0] - {1'b0, dy_q};
          nq_d  = {nq_q[CW-1:0], 1'b1};
        end else begin
          acc_d = trial_s[CW:0];
          nq_d  = {nq_q[CW-1:0], 1'b0};
        end
      end else begin
        cnt_d = cnt_q;
      end
      if (step) begin
        // carry the accumulated fraction into x once it reaches a whole pixel
        if ((dy_q != {CW{1'b0}}) && (rem_sum_s >= {2'b00, dy_q})) begin
          x_d   = x_q + q_s + $signed({{CW{1'b0}}, 1'b1});
          rem_d = rem_sum_s[CW:0] - {1'b0, dy_q};
        end else begin
          x_d   = x_q + q_s;
          rem_d = rem_sum_s[CW:0];
        end
      end else begin
        x_d   = x_q;
        rem_d = rem_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
      acc_q <= {(CW+1){1'b0}};
      nq_q  <= {(CW+1){1'b0}};
      neg_q <= 1'b0;
      dy_q  <= {CW{1'b0}};
      x_q   <= {(CW+1){1'b0}};
      rem_q <= {(CW+1){1'b0}};
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      nq_q  <= nq_d;
      neg_q <= neg_d;
      dy_q  <= dy_d;
      x_q   <= x_d;
      rem_q <= rem_d;
    end
  end

  assign x      = x_q;
  assign rem_nz = (rem_q != {(CW+1){1'b0}});
  assign done   = (cnt_q == CNT_ONE);

endmodule

// File: rtl/trapezoid_raster.sv
// -----------------------------------------------------------------------------
// trapezoid_raster
// Loads four corner points serially, divides both side edges, then emits every
// integer pixel inside the trapezoid row by row (bottom row first, x
// ascending), one pixel per po/pr handshake. Fill mode emits whole spans;
// outline mode emits whole spans on the bottom and top rows and only the two
// span ends on the rows in between.
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of trapezoid_raster_if (nt/mode/xi/yi in,
//           busy/po/xo/yo out, pr in)
// -----------------------------------------------------------------------------
module trapezoid_raster
  import trapezoid_pkg::*;
#(
  parameter int CW = 8
) (
  input logic               clk,
  input logic               reset,
  trapezoid_raster_if.slave bus
);

  localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [1:0]    ld_cnt_q, ld_cnt_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] xul_q, xul_d;
  logic [CW-1:0] xur_q, xur_d;
  logic [CW-1:0] xdl_q, xdl_d;
  logic [CW-1:0] yu_q, yu_d;
  logic [CW-1:0] yd_q, yd_d;
  logic [CW-1:0] y_q, y_d;     // current row
  logic [CW-1:0] xl_q, xl_d;   // span bounds of the current row
  logic [CW-1:0] xr_q, xr_d;
  logic          busy_q, busy_d;
  logic          po_q, po_d;
  logic [CW-1:0] xo_q, xo_d;   // also serves as the span counter
  logic [CW-1:0] yo_q, yo_d;

  logic               start_s;
  logic               step_s;
  logic signed [CW:0] dx_l_s;
  logic signed [CW:0] dx_r_s;
  logic [CW-1:0]      dy_s;
  logic signed [CW:0] x_l_s;
  logic signed [CW:0] x_r_s;
  logic               nz_l_s;
  logic               nz_r_s;
  logic               done_l_s;
  logic               done_r_s;

  logic signed [CW+1:0] xl_s;
  logic signed [CW+1:0] xr_s;
  logic                 row_empty_s;
  logic                 last_row_s;
  logic                 full_row_s;
  logic [CW-1:0]        next_x_s;

  // The right edge starts while its bottom point is still on xi.
  assign dx_l_s = {1'b0, xul_q} - {1'b0, xdl_q};
  assign dx_r_s = {1'b0, xur_q} - {1'b0, bus.xi};
  assign dy_s   = yu_q - yd_q;

  trap_edge_walker #(.CW(CW)) u_left (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .step   (step_s),
    .x0     (xdl_q),
    .dx     (dx_l_s),
    .dy     (dy_s),
    .x      (x_l_s),
    .rem_nz (nz_l_s),
    .done   (done_l_s)
  );

  trap_edge_walker #(.CW(CW)) u_right (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .step   (step_s),
    .x0     (bus.xi),
    .dx     (dx_r_s),
    .dy     (dy_s),
    .x      (x_r_s),
    .rem_nz (nz_r_s),
    .done   (done_r_s)
  );

  // Row bounds: ceiling of the left edge, floor of the right edge.
  always_comb begin
    xl_s        = {x_l_s[CW], x_l_s} + {{(CW+1){1'b0}}, nz_l_s};
    xr_s        = {x_r_s[CW], x_r_s};
    row_empty_s = (xl_s > xr_s);
    last_row_s  = (y_q == yu_q);
    full_row_s  = (mode_q == MODE_FILL) || (y_q == yd_q) || last_row_s;
    // an outline middle row jumps straight from its left end to its right end
    if (!full_row_s && (xo_q == xl_q)) begin
      next_x_s = xr_q;
    end else begin
      next_x_s = xo_q + ONE_CW;
    end
  end

  // FSM next-state, point capture and pixel output sequencing.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    mode_d   = mode_q;
    xul_d    = xul_q;
    xur_d    = xur_q;
    xdl_d    = xdl_q;
    yu_d     = yu_q;
    yd_d     = yd_q;
    y_d      = y_q;
    xl_d     = xl_q;
    xr_d     = xr_q;
    busy_d   = busy_q;
    po_d     = po_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    start_s  = 1'b0;
    step_s   = 1'b0;
    nz_r_unused_guard: begin end
    case (state_q)
      IDLE: begin
        if (bus.nt) begin
          state_d  = LOAD;
          ld_cnt_d = 2'd1;
          mode_d   = bus.mode;
          xul_d    = bus.xi;
          yu_d     = bus.yi;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        case (ld_cnt_q)
          2'd1: begin
            xur_d    = bus.xi;
            ld_cnt_d = 2'd2;
          end
          2'd2: begin
            xdl_d    = bus.xi;
            yd_d     = bus.yi;
            ld_cnt_d = 2'd3;
          end
          2'd3: begin
            start_s  = 1'b1;
            ld_cnt_d = 2'd0;
            state_d  = DIV;
          end
          default: begin
            ld_cnt_d = 2'd0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        endcase
      end
      DIV: begin
        if (done_l_s && done_r_s) begin
          state_d = ROW;
          y_d     = yd_q;
        end else begin
          state_d = DIV;
        end
      end
      ROW: begin
        if (!row_empty_s) begin
          state_d = EMIT;
          po_d    = 1'b1;
          xo_d    = xl_s[CW-1:0];
          yo_d    = y_q;
          xl_d    = xl_s[CW-1:0];
          xr_d    = x_r_s[CW-1:0];
        end else if (last_row_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          step_s  = 1'b1;
          y_d     = y_q + ONE_CW;
        end
      end
      EMIT: begin
        if (bus.pr) begin
          if (xo_q == xr_q) begin
            po_d = 1'b0;
            if (last_row_s) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ROW;
              step_s  = 1'b1;
              y_d     = y_q + ONE_CW;
            end
          end else begin
            xo_d = next_x_s;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        po_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ld_cnt_q <= 2'd0;
      mode_q   <= MODE_FILL;
      xul_q    <= {CW{1'b0}};
      xur_q    <= {CW{1'b0}};
      xdl_q    <= {CW{1'b0}};
      yu_q     <= {CW{1'b0}};
      yd_q     <= {CW{1'b0}};
      y_q      <= {CW{1'b0}};
      xl_q     <= {CW{1'b0}};
      xr_q     <= {CW{1'b0}};
      busy_q   <= 1'b0;
      po_q     <= 1'b0;
      xo_q     <= {CW{1'b0}};
      yo_q     <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      mode_q   <= mode_d;
      xul_q    <= xul_d;
      xur_q    <= xur_d;
      xdl_q    <= xdl_d;
      yu_q     <= yu_d;
      yd_q     <= yd_d;
      y_q      <= y_d;
      xl_q     <= xl_d;
      xr_q     <= xr_d;
      busy_q   <= busy_d;
      po_q     <= po_d;
      xo_q     <= xo_d;
      yo_q     <= yo_d;
    end
  end

  // The right edge is always floored, so its fraction flag is not needed.
  logic unused_s;
  assign unused_s = nz_r_s;

  assign bus.busy = busy_q;
  assign bus.po   = po_q;
  assign bus.xo   = xo_q;
  assign bus.yo   = yo_q;

endmodule

// File: tb/tb_trapezoid_raster.sv
// -----------------------------------------------------------------------------
// tb_trapezoid_raster
// Directed bench for trapezoid_raster: a CW=8 instance for most shapes and a
// CW=12 instance for wide coordinates. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trapezoid_raster;

  logic        clk = 1'b0;
  logic        reset;
  logic        nt_s;
  logic        mode_s;
  logic        pr_s;
  logic        sel12;
  logic [15:0] xi_s;
  logic [15:0] yi_s;

  int n_cmp     = 0;
  int n_fail    = 0;
  int last_wait = 0;

  logic [31:0] mon_po;
  logic [31:0] mon_busy;
  logic [31:0] mon_xo;
  logic [31:0] mon_yo;

  trapezoid_raster_if #(.CW(8))  b8  ();
  trapezoid_raster_if #(.CW(12)) b12 ();

  assign b8.nt    = nt_s & ~sel12;
  assign b8.mode  = mode_s;
  assign b8.xi    = xi_s[7:0];
  assign b8.yi    = yi_s[7:0];
  assign b8.pr    = pr_s;
  assign b12.nt   = nt_s & sel12;
  assign b12.mode = mode_s;
  assign b12.xi   = xi_s[11:0];
  assign b12.yi   = yi_s[11:0];
  assign b12.pr   = pr_s;

  trapezoid_raster #(.CW(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  trapezoid_raster #(.CW(12)) u12 (
    .clk   (clk),
    .reset (reset),
    .bus   (b12)
  );

  assign mon_po   = sel12 ? {31'd0, b12.po}   : {31'd0, b8.po};
  assign mon_busy = sel12 ? {31'd0, b12.busy} : {31'd0, b8.busy};
  assign mon_xo   = sel12 ? {20'd0, b12.xo}   : {24'd0, b8.xo};
  assign mon_yo   = sel12 ? {20'd0, b12.yo}   : {24'd0, b8.yo};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the engine idle; returns on the falling
  // edge after the fourth point has been captured.
  task automatic load(input int xul, input int yu, input int xur,
                      input int xdl, input int yd, input int xdr, input logic md);
    nt_s   = 1'b1;
    mode_s = md;
    xi_s   = 16'(xul);
    yi_s   = 16'(yu);
    @(negedge clk);
    check("busy_after_t0", mon_busy, 32'd1);
    nt_s = 1'b0;
    xi_s = 16'(xur);
    @(negedge clk);
    xi_s = 16'(xdl);
    yi_s = 16'(yd);
    @(negedge clk);
    xi_s = 16'(xdr);
    @(negedge clk);
    xi_s = 16'd0;
    yi_s = 16'd0;
  endtask

  // Waits (bounded) for po, checks the pixel, then steps past its transfer.
  task automatic expect_pix(input int x, input int y);
    int w;
    w = 0;
    while (mon_po !== 32'd1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check($sformatf("pix(%0d,%0d).po", x, y), mon_po, 32'd1);
    check($sformatf("pix(%0d,%0d).xo", x, y), mon_xo, 32'(x));
    check($sformatf("pix(%0d,%0d).yo", x, y), mon_yo, 32'(y));
    @(negedge clk);
  endtask

  int lo5[3] = '{1, 1, 0};
  int hi5[3] = '{4, 3, 3};

  initial begin
    reset  = 1'b1;
    nt_s   = 1'b0;
    mode_s = 1'b0;
    pr_s   = 1'b1;
    sel12  = 1'b0;
    xi_s   = 16'd0;
    yi_s   = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", mon_busy, 32'd0);
    check("rst_po",   mon_po,   32'd0);
    check("rst_xo",   mon_xo,   32'd0);
    check("rst_yo",   mon_yo,   32'd0);
    reset = 1'b0;

    // Fill rectangle with first-pixel latency and row bubble
    load(2, 5, 4, 2, 3, 4, 1'b0);
    repeat (9) @(negedge clk);
    check("t1_po_before_first", mon_po, 32'd0);
    @(negedge clk);
    check("t1_po_first", mon_po, 32'd1);
    for (int y = 3; y <= 5; y++) begin
      for (int x = 2; x <= 4; x++) begin
        expect_pix(x, y);
        if (x == 2 && y != 3) check("t1_row_bubble", last_wait, 32'd1);
      end
    end
    check("t1_busy_end", mon_busy, 32'd0);
    check("t1_po_end",   mon_po,   32'd0);

    // Fractional left edge, next trapezoid with no idle, nt ignored while busy
    load(1, 3, 4, 0, 0, 4, 1'b0);
    nt_s = 1'b1;
    xi_s = 16'd9;
    repeat (3) @(negedge clk);
    nt_s = 1'b0;
    xi_s = 16'd0;
    for (int y = 0; y <= 3; y++) begin
      for (int x = (y == 0) ? 0 : 1; x <= 4; x++) begin
        expect_pix(x, y);
      end
    end
    check("t2_busy_end", mon_busy, 32'd0);

    // Outline mode
    load(0, 3, 3, 0, 0, 3, 1'b1);
    for (int y = 0; y <= 3; y++) begin
      if (y == 0 || y == 3) begin
        for (int x = 0; x <= 3; x++) expect_pix(x, y);
      end else begin
        expect_pix(0, y);
        expect_pix(3, y);
      end
    end
    check("t3_busy_end", mon_busy, 32'd0);

    // Back-pressure: sink stalls for 3 cycles on pixel (3,4)
    load(2, 5, 4, 2, 3, 4, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        pr_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t4_hold_po", mon_po, 32'd1);
          check("t4_hold_xo", mon_xo, 32'd3);
          check("t4_hold_yo", mon_yo, 32'd4);
        end
        pr_s = 1'b1;
      end
      expect_pix(2 + (i % 3), 3 + (i / 3));
    end
    check("t4_busy_end", mon_busy, 32'd0);

    // Single-row trapezoid (dy = 0)
    load(2, 6, 5, 2, 6, 5, 1'b0);
    for (int x = 2; x <= 5; x++) expect_pix(x, 6);
    check("t5a_busy_end", mon_busy, 32'd0);

    // Narrowing to a point: 5 + 3 + 1 pixels
    load(5, 7, 5, 3, 5, 7, 1'b0);
    for (int y = 5; y <= 7; y++) begin
      for (int x = y - 2; x <= 12 - y; x++) expect_pix(x, y);
    end
    check("t5b_busy_end", mon_busy, 32'd0);

    // Negative slopes with non-zero remainder
    load(0, 2, 3, 1, 0, 4, 1'b0);
    for (int y = 0; y <= 2; y++) begin
      for (int x = lo5[y]; x <= hi5[y]; x++) expect_pix(x, y);
    end
    check("t5c_busy_end", mon_busy, 32'd0);

    // Reset mid-EMIT, then a shape with an empty middle row
    load(2, 5, 4, 2, 3, 4, 1'b0);
    expect_pix(2, 3);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", mon_busy, 32'd0);
    check("t6_rst_po",   mon_po,   32'd0);
    check("t6_rst_xo",   mon_xo,   32'd0);
    check("t6_rst_yo",   mon_yo,   32'd0);
    reset = 1'b0;
    load(1, 2, 1, 0, 0, 0, 1'b0);
    expect_pix(0, 0);
    expect_pix(1, 2);
    check("t6_empty_row_cost", last_wait, 32'd2);
    check("t6_busy_end", mon_busy, 32'd0);

    // Wide coordinates on the CW = 12 instance
    sel12 = 1'b1;
    load(1002, 605, 1004, 1002, 603, 1004, 1'b0);
    repeat (13) @(negedge clk);
    check("t7_po_before_first", mon_po, 32'd0);
    @(negedge clk);
    check("t7_po_first", mon_po, 32'd1);
    for (int y = 603; y <= 605; y++) begin
      for (int x = 1002; x <= 1004; x++) expect_pix(x, y);
    end
    check("t7_busy_end", mon_busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trapezoid_raster.md
# trapezoid_raster

Parametrised trapezoid rendering engine. It accepts four corner points serially, then emits every integer pixel inside the trapezoid, one per handshake, scanning row by row. It extends the fixed 8-bit engine with:
- a configurable coordinate width;
- a fill/outline mode;
- output back-pressure (`pr`);
- exact ceil/floor edge rounding via a per-edge divider.

It sits between the point-command source and the pixel sink in the rendering datapath.

## Interface
- `CW`, 8, coordinate width in bits (unsigned), legal range 4..16
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `nt`  in  1  new trapezoid; high with the first point only
- `mode`  in  1  sampled with `nt`: 0 = fill, 1 = outline
- `xi`, `yi`  in  CW each  point coordinates
- `busy`  out  1  high while loading or rendering
- `po`  out  1  pixel valid
- `pr`  in  1  sink ready; a transfer occurs on a rising edge with `po` = `pr` = 1
- `xo`, `yo`  out  CW each  pixel coordinates

## Operation
- **Load order:** (xul,yu), (xur,yu), (xdl,yd), (xdr,yd) on four consecutive edges, starting with the edge where `nt` = 1 and `busy` = 0.
  - `nt` is ignored while `busy` = 1.
  - The caller guarantees yd ≤ yu, xul ≤ xur and xdl ≤ xdr. No checking is done.
- **States and transitions:**
  - IDLE → LOAD on `nt`.
  - LOAD (4 points) → DIV.
  - DIV → ROW.
  - ROW → EMIT, or → ROW for an empty row.
  - EMIT → ROW at the end of a span, or → IDLE after the last pixel of row yu.
- **DIV (CW+1 cycles):** both edges in parallel.
  - Let dy = yu − yd.
  - Left edge: dxL = xul − xdl, signed CW+1 bits. Right edge: dxR = xur − xdr, likewise.
  - Restoring divide gives floor quotient q and remainder r ∈ [0, dy).
  - If dy = 0, DIV still takes CW+1 cycles and q = r = 0.
- **Edge walk:**
  - Each edge keeps an integer x and a remainder rem, initialised to (xdl, 0) and (xdr, 0).
  - Per row advance: x += q; rem += r; if rem ≥ dy then x += 1 and rem −= dy.
  - Internal widths: remainder CW+1 bits, x CW+1 bits signed.
- **Row bounds:**
  - Left bound xl = xL + (remL ≠ 0), i.e. the ceiling.
  - Right bound xr = xR, i.e. the floor.
  - A row with xl > xr emits nothing.
- **Scan order:** rows y = yd ascending to yu. Within a row, x ascends from xl to xr.
- **Fill mode:** every x in [xl, xr].
- **Outline mode:**
  - Rows yd and yu emit the full span.
  - Other rows emit xl and xr only, or a single pixel if xl = xr.
- `xo`/`yo` are always within the hull of the inputs; no clipping is needed.

## Timing
- **Reset values:** `busy` = 0, `po` = 0, `xo` = 0, `yo` = 0, state IDLE.
- **Load timing:** T0 is the edge capturing point 0. Points are captured on T0..T3.
- **`busy`:** high from T0+1. It falls on the edge after the final transfer.
- **DIV and first pixel:** DIV occupies T4..T4+CW; the first ROW is at T5+CW. With `pr` = 1, the first `po` is high in the cycle after edge T5+CW.
- **Row bubbles:** each row costs exactly one ROW cycle with `po` = 0. An empty row costs one cycle.
- **Back-pressure:** while `po` = 1 and `pr` = 0, `po`, `xo` and `yo` hold stable. No pixel is skipped or duplicated.
- **Next trapezoid:** accepted the edge after `busy` falls, giving zero extra idle.
- **Reset mid-operation:** the next edge returns IDLE with all outputs at reset values. Partial state is discarded.

## Structure
- **Package `trapezoid_pkg`:** state enum (IDLE, LOAD, DIV, ROW, EMIT) and mode constants MODE_FILL and MODE_OUTLINE.
- **Sub-module `trap_edge_walker`:** parametrised by CW; instantiated twice, once per edge.
  - Contains the restoring divider, the x/rem registers and the step logic.
  - Ports: start, step, x0, dx, dy, x, rem_nz, done.
- **Top module:** FSM, point registers, row counter, span counter and output register.

## Test plan
- **Fill rectangle:** CW = 8, points (2,5),(4,5),(2,3),(4,3), mode 0, `pr` = 1 → 9 pixels (2,3)(3,3)(4,3)(2,4)…(4,5); first `po` in the cycle after T13; `busy` low the edge after the 9th pixel.
- **Fractional edges:** (1,3),(4,3),(0,0),(4,0) → row 0 x 0..4; rows 1–3 x 1..4; 17 pixels total.
- **Outline mode:** (0,3),(3,3),(0,0),(3,0), mode 1 → rows 0 and 3 give 4 pixels each; rows 1 and 2 give x = 0 and x = 3 only; 12 pixels.
- **Back-pressure:** as the first case, with `pr` low for 3 cycles at pixel 4 → (3,4) held stable for 3 cycles; the full 9-pixel sequence is unchanged.
- **Degenerate shapes:**
  - yu = yd = 6, xdl = 2, xdr = 5 → 4 pixels on row 6.
  - (5,7),(5,7),(3,5),(7,5) → 5 + 3 + 1 = 9 pixels.
  - A row with xl > xr emits nothing, costs one cycle, and the scan continues.
- **Reset and parameters:** `reset` pulsed mid-EMIT → `busy` and `po` are 0 the next cycle; a new trapezoid loaded immediately renders correctly. Repeat the first case with CW = 12 and coordinates above 255.
